// File: rtl/reg_cmd_pkg.sv
// Shared command/status codes and FSM state type for the register command engine.
package reg_cmd_pkg;

  localparam logic [7:0] CMD_NOP   = 8'h00;
  localparam logic [7:0] CMD_WRITE = 8'h0a;
  localparam logic [7:0] CMD_READ  = 8'ha0;

  typedef logic [7:0] rsp_status_t;

  localparam rsp_status_t ST_OK       = 8'h00;
  localparam rsp_status_t ST_BAD_CMD  = 8'hE1;
  localparam rsp_status_t ST_BAD_ADDR = 8'hE2;
  localparam rsp_status_t ST_TIMEOUT  = 8'hE3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_READ    = 3'd2,
    S_WAIT_RD = 3'd3,
    S_RESP    = 3'd4
  } state_t;

endpackage

// File: rtl/reg_cmd_decode.sv
// Combinational decode of an incoming frame's cmd/addr into the first
// post-accept state and the status to report if it goes straight to RESP.
module reg_cmd_decode
  import reg_cmd_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int NUM_REGS   = 16
) (
  input  logic [WORD_WIDTH-1:0] cmd,
  input  logic [WORD_WIDTH-1:0] addr,
  output state_t                next_state,
  output rsp_status_t           status
);

  localparam logic [WORD_WIDTH:0] ADDR_LIMIT = (WORD_WIDTH + 1)'(NUM_REGS);

  logic is_write;
  logic is_read;

  assign is_write = (cmd == WORD_WIDTH'(CMD_WRITE));
  assign is_read  = (cmd == WORD_WIDTH'(CMD_READ));

  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = S_IDLE;
    status     = ST_OK;
    if (cmd == WORD_WIDTH'(CMD_NOP)) begin
      next_state = S_IDLE;
    end else if (!is_write && !is_read) begin
      next_state = S_RESP;
      status     = ST_BAD_CMD;
    end else if ({1'b0, addr} >= ADDR_LIMIT) begin
      next_state = S_RESP;
      status     = ST_BAD_ADDR;
    end else if (is_write) begin
      next_state = S_WRITE;
    end else begin
      next_state = S_READ;
    end
  end

endmodule

// File: rtl/reg_command_engine.sv
// Command frame -> register access -> response frame engine with read timeout
// and a saturating error counter.
module reg_command_engine
  import reg_cmd_pkg::*;
#(
  parameter int WORD_WIDTH  = 8,
  parameter int VALUE_WORDS = 4,
  parameter int NUM_REGS    = 16,
  parameter int RD_TIMEOUT  = 15,
  parameter int ACK_WRITES  = 1
) (
  input  logic                                 clk,
  input  logic                                 i_reset,
  input  logic [(VALUE_WORDS+2)*WORD_WIDTH-1:0] i_frame,
  input  logic                                 i_valid,
  output logic                                 o_ready,
  output logic                                 o_reg_w_en,
  output logic                                 o_reg_r_en,
  output logic [WORD_WIDTH-1:0]                o_reg_addr,
  output logic [VALUE_WORDS*WORD_WIDTH-1:0]    o_reg_wdata,
  input  logic [VALUE_WORDS*WORD_WIDTH-1:0]    i_reg_rdata,
  input  logic                                 i_reg_rvalid,
  output logic [(VALUE_WORDS+2)*WORD_WIDTH-1:0] o_rsp_frame,
  output logic                                 o_rsp_valid,
  input  logic                                 i_rsp_ready,
  output logic [15:0]                          o_err_count
);

  localparam int VAL_W = VALUE_WORDS * WORD_WIDTH;
  localparam int FW    = VAL_W + 2 * WORD_WIDTH;
  localparam int TW    = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(RD_TIMEOUT - 1);

  state_t                  state;
  logic [WORD_WIDTH-1:0]   cmd_q;
  logic [WORD_WIDTH-1:0]   addr_q;
  logic [VAL_W-1:0]        value_q;
  logic [TW-1:0]           timer;
  logic [FW-1:0]           rsp_frame;
  logic [15:0]             err_count;

  logic [WORD_WIDTH-1:0]   f_cmd;
  logic [WORD_WIDTH-1:0]   f_addr;
  logic [VAL_W-1:0]        f_value;
  state_t                  dec_state;
  rsp_status_t             dec_status;
  logic                    rsp_is_err;

  assign f_cmd   = i_frame[FW-1 -: WORD_WIDTH];
  assign f_addr  = i_frame[VAL_W +: WORD_WIDTH];
  assign f_value = i_frame[VAL_W-1:0];

  reg_cmd_decode #(
    .WORD_WIDTH (WORD_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_decode (
    .cmd        (f_cmd),
    .addr       (f_addr),
    .next_state (dec_state),
    .status     (dec_status)
  );

  assign rsp_is_err = (rsp_frame[VAL_W +: WORD_WIDTH] != WORD_WIDTH'(ST_OK));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state     <= S_IDLE;
      cmd_q     <= '0;
      addr_q    <= '0;
      value_q   <= '0;
      timer     <= '0;
      rsp_frame <= '0;
      err_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            cmd_q   <= f_cmd;
            addr_q  <= f_addr;
            value_q <= f_value;
            state   <= dec_state;
            if (dec_state == S_RESP)
              rsp_frame <= {f_cmd, WORD_WIDTH'(dec_status), {VAL_W{1'b0}}};
          end
        end
        S_WRITE: begin
          if (ACK_WRITES != 0) begin
            state     <= S_RESP;
            rsp_frame <= {cmd_q, WORD_WIDTH'(ST_OK), value_q};
          end else begin
            state <= S_IDLE;
          end
        end
        S_READ: begin
          timer <= '0;
          if (i_reg_rvalid) begin
            state     <= S_RESP;
            rsp_frame <= {cmd_q, WORD_WIDTH'(ST_OK), i_reg_rdata};
          end else begin
            state <= S_WAIT_RD;
          end
        end
        S_WAIT_RD: begin
          // Data arriving on the expiry cycle still counts as a successful read.
          if (i_reg_rvalid) begin
            state     <= S_RESP;
            rsp_frame <= {cmd_q, WORD_WIDTH'(ST_OK), i_reg_rdata};
          end else if (timer == TIMER_LAST) begin
            state     <= S_RESP;
            rsp_frame <= {cmd_q, WORD_WIDTH'(ST_TIMEOUT), {VAL_W{1'b0}}};
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            state <= S_IDLE;
            if (rsp_is_err && err_count != 16'hFFFF)
              err_count <= err_count + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_ready     = (state == S_IDLE);
  assign o_reg_w_en  = (state == S_WRITE);
  assign o_reg_r_en  = (state == S_READ);
  assign o_rsp_valid = (state == S_RESP);
  assign o_reg_addr  = addr_q;
  assign o_reg_wdata = value_q;
  assign o_rsp_frame = rsp_frame;
  assign o_err_count = err_count;

endmodule

// File: tb/tb_reg_command_engine.sv
// Randomized scoreboard bench for reg_command_engine: a behavioural register
// bank model predicts responses, strobes and the error count.
module tb_reg_command_engine;

  localparam int WW = 8;
  localparam int VW = 4;
  localparam int NR = 16;
  localparam int TO = 15;
  localparam int FW = (VW + 2) * WW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          i_reset;
  logic [FW-1:0] i_frame;
  logic          i_valid;
  logic          o_ready;
  logic          o_reg_w_en;
  logic          o_reg_r_en;
  logic [7:0]    o_reg_addr;
  logic [31:0]   o_reg_wdata;
  logic [31:0]   i_reg_rdata;
  logic          i_reg_rvalid;
  logic [FW-1:0] o_rsp_frame;
  logic          o_rsp_valid;
  logic          i_rsp_ready;
  logic [15:0]   o_err_count;

  logic          n_valid, n_ready, n_w_en, n_r_en, n_rsp_valid;
  logic [7:0]    n_addr;
  logic [31:0]   n_wdata;
  logic [FW-1:0] n_rsp_frame;
  logic [15:0]   n_err;

  reg_command_engine #(.WORD_WIDTH(WW), .VALUE_WORDS(VW), .NUM_REGS(NR),
                       .RD_TIMEOUT(TO), .ACK_WRITES(1)) u_dut (
    .clk(clk), .i_reset(i_reset), .i_frame(i_frame), .i_valid(i_valid),
    .o_ready(o_ready), .o_reg_w_en(o_reg_w_en), .o_reg_r_en(o_reg_r_en),
    .o_reg_addr(o_reg_addr), .o_reg_wdata(o_reg_wdata), .i_reg_rdata(i_reg_rdata),
    .i_reg_rvalid(i_reg_rvalid), .o_rsp_frame(o_rsp_frame), .o_rsp_valid(o_rsp_valid),
    .i_rsp_ready(i_rsp_ready), .o_err_count(o_err_count)
  );

  reg_command_engine #(.WORD_WIDTH(WW), .VALUE_WORDS(VW), .NUM_REGS(NR),
                       .RD_TIMEOUT(TO), .ACK_WRITES(0)) u_dut_nack (
    .clk(clk), .i_reset(i_reset), .i_frame(i_frame), .i_valid(n_valid),
    .o_ready(n_ready), .o_reg_w_en(n_w_en), .o_reg_r_en(n_r_en),
    .o_reg_addr(n_addr), .o_reg_wdata(n_wdata), .i_reg_rdata(32'h0),
    .i_reg_rvalid(1'b0), .o_rsp_frame(n_rsp_frame), .o_rsp_valid(n_rsp_valid),
    .i_rsp_ready(1'b1), .o_err_count(n_err)
  );

  logic [31:0]   model_mem [NR];
  logic [31:0]   bank      [NR];
  logic [FW-1:0] exp_rsp_q [$];
  logic [39:0]   exp_wr_q  [$];
  logic [7:0]    exp_rd_q  [$];
  int            exp_err;
  int            rd_delay;
  int            n_checks = 0;
  int            n_pass   = 0;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: expected event did not occur as required (t=%0t)", name, $time);
  endtask

  // Response scoreboard: every handshake pops one expected frame.
  always @(negedge clk) begin
    if (!i_reset && o_rsp_valid && i_rsp_ready) begin
      if (exp_rsp_q.size() == 0) fail("rsp_unexpected");
      else check("rsp_frame", o_rsp_frame, exp_rsp_q.pop_front());
    end
    if (!i_reset && o_reg_w_en) begin
      if (exp_wr_q.size() == 0) fail("w_en_unexpected");
      else check("w_en_addr_data", {o_reg_addr, o_reg_wdata}, exp_wr_q.pop_front());
      if (o_reg_addr < NR) bank[o_reg_addr[3:0]] = o_reg_wdata;
    end
    if (!i_reset && o_reg_r_en) begin
      if (exp_rd_q.size() == 0) fail("r_en_unexpected");
      else check("r_en_addr", o_reg_addr, exp_rd_q.pop_front());
    end
  end

  // Register bank responder: rvalid rd_delay cycles after the read strobe (-1 = never).
  initial begin
    i_reg_rvalid = 1'b0;
    i_reg_rdata  = '0;
    forever begin
      @(posedge clk); #1;
      if (o_reg_r_en && !i_reset) begin
        int d;
        logic [31:0] data;
        d    = rd_delay;
        data = bank[o_reg_addr[3:0]];
        if (d >= 0) begin
          repeat (d) begin @(posedge clk); #1; end
          i_reg_rvalid = 1'b1;
          i_reg_rdata  = data;
          @(posedge clk); #1;
          i_reg_rvalid = 1'b0;
          i_reg_rdata  = $urandom;
        end
      end
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (!o_ready && n < 60) begin @(posedge clk); #1; n++; end
    if (!o_ready) fail(name);
  endtask

  task automatic send(input logic [7:0] cmd, input logic [7:0] addr,
                      input logic [31:0] val, input int delay, input int hold);
    logic [FW-1:0] exp;
    logic [FW-1:0] snap;
    bit has_rsp;
    bit ok_addr;
    bit legal;
    int n;
    exp     = '0;
    has_rsp = 1'b1;
    ok_addr = (addr < NR);
    legal   = (cmd == 8'h0a) || (cmd == 8'ha0);
    if (cmd == 8'h00) has_rsp = 1'b0;
    else if (!legal) exp = {cmd, 8'hE1, 32'h0};
    else if (!ok_addr) exp = {cmd, 8'hE2, 32'h0};
    else if (cmd == 8'h0a) begin
      exp = {cmd, 8'h00, val};
      model_mem[addr[3:0]] = val;
      exp_wr_q.push_back({addr, val});
    end else begin
      exp_rd_q.push_back(addr);
      if (delay >= 0 && delay <= TO) exp = {cmd, 8'h00, model_mem[addr[3:0]]};
      else exp = {cmd, 8'hE3, 32'h0};
    end
    if (has_rsp) begin
      exp_rsp_q.push_back(exp);
      if (exp[39:32] != 8'h00) exp_err++;
    end

    rd_delay    = delay;
    i_rsp_ready = (hold == 0);
    wait_ready("accept_wait");
    i_frame = {cmd, addr, val};
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_frame = '0;

    if (cmd == 8'h0a && ok_addr) begin
      check("w_en_latency", o_reg_w_en, 1);
      @(posedge clk); #1;
      check("wr_rsp_latency", o_rsp_valid, 1);
    end else if (cmd == 8'ha0 && ok_addr && delay == 0) begin
      check("r_en_latency", o_reg_r_en, 1);
      @(posedge clk); #1;
      check("rd_rsp_latency", o_rsp_valid, 1);
    end else if (!has_rsp) begin
      check("nop_ready_next", o_ready, 1);
    end else begin
      check("busy_not_ready", o_ready, 0);
    end

    if (has_rsp && hold > 0) begin
      n = 0;
      while (!o_rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
      snap = o_rsp_frame;
      repeat (hold) begin
        @(posedge clk); #1;
        check("bp_valid_held", o_rsp_valid, 1);
        check("bp_frame_stable", o_rsp_frame, snap);
        check("bp_not_ready", o_ready, 0);
      end
      i_rsp_ready = 1'b1;
    end
    wait_ready("done_wait");
    check("err_count", o_err_count, exp_err);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      logic [31:0] v;
      v = $urandom;
      model_mem[i] = v;
      bank[i]      = v;
    end
    exp_err     = 0;
    rd_delay    = -1;
    i_reset     = 1'b1;
    i_valid     = 1'b0;
    n_valid     = 1'b0;
    i_rsp_ready = 1'b1;
    i_frame     = '0;
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b0;

    check("rst_ready", o_ready, 1);
    check("rst_rsp_valid", o_rsp_valid, 0);
    check("rst_rsp_frame", o_rsp_frame, 0);
    check("rst_err_count", o_err_count, 0);
    check("rst_strobes", {o_reg_w_en, o_reg_r_en}, 0);
    check("rst_latched", {o_reg_addr, o_reg_wdata}, 0);

    send(8'h0a, 8'h03, 32'hDEADBEEF, 0, 0);
    send(8'h0a, 8'h05, 32'h12345678, 0, 0);
    send(8'ha0, 8'h05, 32'h0, 3, 0);
    send(8'ha0, 8'h03, 32'h0, 0, 0);
    send(8'ha0, 8'h02, 32'h0, 16, 0);
    send(8'ha0, 8'h02, 32'h0, 15, 0);
    send(8'h55, 8'h01, 32'h11111111, 0, 0);
    send(8'h0a, 8'h10, 32'h22222222, 0, 0);
    send(8'ha0, 8'h10, 32'h0, 0, 0);
    send(8'h0a, 8'h04, 32'hA5A5A5A5, 0, 10);
    send(8'h00, 8'h02, 32'h0, 0, 0);

    // Silent-write variant: strobe but never a response.
    i_frame = {8'h0a, 8'h07, 32'hCAFEF00D};
    n_valid = 1'b1;
    @(posedge clk); #1;
    n_valid = 1'b0;
    check("nack_w_en", n_w_en, 1);
    check("nack_addr_data", {n_addr, n_wdata}, {8'h07, 32'hCAFEF00D});
    @(posedge clk); #1;
    check("nack_ready", n_ready, 1);
    check("nack_no_rsp", n_rsp_valid, 0);
    i_frame = '0;

    for (int k = 0; k < 150; k++) begin
      int sel;
      logic [7:0] c;
      int hold;
      sel = $urandom_range(0, 9);
      if (sel <= 3) c = 8'h0a;
      else if (sel <= 6) c = 8'ha0;
      else if (sel == 7) c = 8'h00;
      else begin
        c = 8'($urandom);
        if (c == 8'h00 || c == 8'h0a || c == 8'ha0) c = 8'h33;
      end
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      send(c, 8'($urandom_range(0, 19)), $urandom, $urandom_range(0, 18), hold);
    end

    // Reset while waiting for read data.
    rd_delay = -1;
    exp_rd_q.push_back(8'h06);
    i_frame = {8'ha0, 8'h06, 32'h0};
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("wait_rd_busy", o_ready, 0);
    i_reset = 1'b1;
    @(posedge clk); #1;
    i_reset = 1'b0;
    exp_err = 0;
    check("rst_wait_ready", o_ready, 1);
    check("rst_wait_rsp_valid", o_rsp_valid, 0);
    check("rst_wait_err", o_err_count, 0);
    check("rst_wait_strobes", {o_reg_w_en, o_reg_r_en}, 0);
    @(posedge clk); #1;
    check("rst_wait_strobes_next", {o_reg_w_en, o_reg_r_en}, 0);

    // Reset while a response is pending; it must be discarded.
    i_rsp_ready = 1'b0;
    i_frame = {8'h77, 8'h01, 32'h0};
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    check("resp_pending", o_rsp_valid, 1);
    i_reset = 1'b1;
    @(posedge clk); #1;
    i_reset = 1'b0;
    check("rst_resp_ready", o_ready, 1);
    check("rst_resp_valid", o_rsp_valid, 0);
    check("rst_resp_frame", o_rsp_frame, 0);
    check("rst_resp_err", o_err_count, 0);
    i_rsp_ready = 1'b1;

    send(8'h0a, 8'h09, 32'h0BADF00D, 0, 0);
    send(8'ha0, 8'h09, 32'h0, 2, 0);

    repeat (3) @(posedge clk);
    check("rsp_queue_drained", exp_rsp_q.size(), 0);
    check("wr_queue_drained", exp_wr_q.size(), 0);
    check("rd_queue_drained", exp_rd_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_command_engine.md
Name: reg_command_engine

Overview:
Parametrised successor to the single-frame command decoder.
- Accepts a command frame over a valid/ready handshake and decodes it.
- Executes the decoded access against a register-file port, with variable read latency and a timeout.
- Returns a status/response frame over a second valid/ready handshake. Sits between the host-link deframer and the register bank.

Parameters:
WORD_WIDTH, 8, bits per frame word.
VALUE_WORDS, 4, value field width in words.
NUM_REGS, 16, number of legal addresses (0..NUM_REGS-1).
RD_TIMEOUT, 15, max cycles to wait for read data after the read strobe.
ACK_WRITES, 1, 1 = successful write returns a response; 0 = silent write.

Ports:
clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_frame  in  (VALUE_WORDS+2)*WORD_WIDTH  {cmd, addr, value}, cmd in MSW
i_valid  in  1  frame valid
o_ready  out  1  engine can accept a frame
o_reg_w_en  out  1  register write strobe, one cycle
o_reg_r_en  out  1  register read strobe, one cycle
o_reg_addr  out  WORD_WIDTH  latched address
o_reg_wdata  out  VALUE_WORDS*WORD_WIDTH  latched value
i_reg_rdata  in  VALUE_WORDS*WORD_WIDTH  read data
i_reg_rvalid  in  1  read data valid
o_rsp_frame  out  (VALUE_WORDS+2)*WORD_WIDTH  {cmd echo, status, value}
o_rsp_valid  out  1  response valid
i_rsp_ready  in  1  response consumer ready
o_err_count  out  16  saturating count of non-OK responses

Behaviour:
- Interface: clock clk; reset i_reset, synchronous, active-high.
- Command codes: WRITE = 0x0a, READ = 0xa0, NOP = 0x00; all others are illegal.
- Status codes: OK = 0x00, BAD_CMD = 0xE1, BAD_ADDR = 0xE2, TIMEOUT = 0xE3.
- Reset values: state IDLE; o_ready = 1; all strobes 0; o_rsp_valid = 0; o_rsp_frame = 0; o_err_count = 0; latched addr/value = 0.
- States: IDLE, WRITE, READ, WAIT_RD, RESP.
- Outputs are Moore: o_ready = (state == IDLE), o_reg_w_en = (state == WRITE), o_reg_r_en = (state == READ), o_rsp_valid = (state == RESP).
- IDLE: on i_valid && o_ready, latch cmd/addr/value, then decode:
  - NOP -> IDLE; no response, no strobe.
  - Illegal cmd -> RESP, status BAD_CMD, value 0.
  - READ/WRITE with addr >= NUM_REGS -> RESP, status BAD_ADDR, value 0; no strobe.
  - WRITE -> WRITE.
  - READ -> READ.
- WRITE: strobe is high for exactly the cycle after accept. Next state is RESP (status OK, value = written value) if ACK_WRITES = 1, else IDLE.
- READ: strobe is high for one cycle. Clear the timer. If i_reg_rvalid is high this same cycle, capture data and go to RESP (OK); otherwise go to WAIT_RD.
- WAIT_RD: timer increments each cycle, width $clog2(RD_TIMEOUT+1).
  - i_reg_rvalid -> capture i_reg_rdata, go to RESP (OK).
  - Timer == RD_TIMEOUT - 1 with no rvalid -> RESP, status TIMEOUT, value 0.
  - rvalid in the expiry cycle wins over TIMEOUT.
  - rvalid outside READ/WAIT_RD is ignored.
- RESP: o_rsp_frame is held stable while o_rsp_valid is high. On i_rsp_ready, go to IDLE.
- Throughput: the next frame is accepted no earlier than the cycle after the response handshake.
- o_err_count increments once per response handshake with non-OK status, and saturates at 0xFFFF.
- While busy, o_ready = 0. The upstream block holds the frame; nothing is dropped.
- Reset mid-operation: abort to IDLE. A pending response is discarded, and no strobe is issued on the reset cycle or the cycle after.
- Latencies: accept -> w_en is 1 cycle; accept -> rsp_valid for a write is 2 cycles; for a read with immediate rvalid, 2 cycles.

Decomposition:
- Package reg_cmd_pkg holds:
  - command code localparams;
  - status code localparams;
  - state enum typedef;
  - a rsp_status_t typedef.
- Sub-module reg_cmd_decode: combinational frame decode producing {next_state, status} from cmd, addr and NUM_REGS. Unit-testable in isolation.

Test Plan:
- Write: frame {0x0a, 0x03, 0xDEADBEEF}, rsp_ready = 1 -> w_en one cycle with addr 0x03 and wdata 0xDEADBEEF; response {0x0a, 0x00, 0xDEADBEEF} two cycles after accept.
- Read with 3-cycle latency: frame {0xa0, 0x05, 0}, rvalid three cycles after r_en with rdata 0x12345678 -> response {0xa0, 0x00, 0x12345678}; o_ready low throughout.
- Read timeout: rvalid never asserted -> response {0xa0, 0xE3, 0} after RD_TIMEOUT cycles; o_err_count = 1. Repeat with rvalid on the expiry cycle -> status OK.
- Illegal command and bad address:
  - {0x55, 0x01, x} -> {0x55, 0xE1, 0}, no strobes.
  - {0x0a, 0x10, x} with NUM_REGS = 16 -> {0x0a, 0xE2, 0}, no w_en.
  - o_err_count = 2.
- Backpressure and NOP:
  - i_rsp_ready low for 10 cycles -> rsp_valid and frame stable, o_ready low.
  - NOP frame -> no response, o_ready high the next cycle.
  - ACK_WRITES = 0 write -> no response.
- Reset in WAIT_RD and in RESP -> next cycle state IDLE, o_rsp_valid = 0, o_ready = 1, o_err_count = 0; a new write then completes normally.
